// File: rtl/dm_pkg.sv
// Shared opcodes, FSM encoding and opcode helpers for the data-memory arbiter.
package dm_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the master that did not own the last access wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_valid,
  output logic       o_winner
);

  assign o_valid  = |i_req;
  assign o_winner = (&i_req) ? ~i_last_owner : i_req[1];

endmodule

// File: rtl/dm_arbiter.sv
// Two-master sequencer in front of the data memory: one access per grant, registered response.
//   state  | meaning
//   IDLE   | no access in flight, arbitrate each cycle
//   ACCESS | latched request drives the memory for one cycle
//   RESP   | response to owner; arbitration for the next access runs in parallel
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [OP_W-1:0]   m0_op,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [OP_W-1:0]   m1_op,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wr,
  output logic [OP_W-1:0]   mem_op,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t              r_state;
  logic                r_last;
  logic                r_owner;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [OP_W-1:0]     r_op;

  logic                w_valid;
  logic                w_winner;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [OP_W-1:0]     w_op;
  logic                w_legal;
  logic                w_word;
  logic                w_err;
  logic                w_access;
  logic                w_resp;

  rr_arb2 u_rr_arb2 (
    .i_req        ({m1_req, m0_req}),
    .i_last_owner (r_last),
    .o_valid      (w_valid),
    .o_winner     (w_winner)
  );

  assign w_addr  = w_winner ? m1_addr  : m0_addr;
  assign w_wdata = w_winner ? m1_wdata : m0_wdata;
  assign w_op    = w_winner ? m1_op    : m0_op;

  assign w_legal = is_load(w_op) || is_store(w_op);
  assign w_word  = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_err   = !w_legal || (w_word && (w_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_ACCESS: begin
          r_rdata <= (is_load(r_op) && !r_err) ? mem_dout : '0;
          r_state <= ST_RESP;
        end
        default: begin
          if (w_valid) begin
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_op    <= w_op;
            r_err   <= w_err;
            r_state <= ST_ACCESS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign w_access = (r_state == ST_ACCESS);
  assign w_resp   = (r_state == ST_RESP);

  assign m0_gnt    = w_access & ~r_owner;
  assign m1_gnt    = w_access &  r_owner;
  assign m0_rvalid = w_resp & ~r_owner;
  assign m1_rvalid = w_resp &  r_owner;
  assign m0_rdata  = m0_rvalid ? r_rdata : '0;
  assign m1_rdata  = m1_rvalid ? r_rdata : '0;
  assign m0_err    = m0_rvalid & r_err;
  assign m1_err    = m1_rvalid & r_err;

  // Memory bus is forced to zero outside ACCESS so a write can only happen there.
  assign mem_addr = w_access ? r_addr  : '0;
  assign mem_din  = w_access ? r_wdata : '0;
  assign mem_op   = w_access ? r_op    : '0;
  assign mem_wr   = w_access & is_store(r_op) & ~r_err;

endmodule
